// File: rtl/ssram_burst_arbiter.sv
// rtl/ssram_burst_arbiter.sv - two-requester arbiter for the shared SSRAM burst port
//
// Shares one drv_ssram burst port between the VGA line-fetch DMA (absolute
// priority, fixed-length read bursts) and a general master (read/write
// bursts of arbitrary length, split into chunks of at most M_CHUNK_WORDS so
// VGA never waits longer than one chunk plus turnaround).
//
// Ports:
//   clk_30, reset_n            clock, asynchronous active-low reset
//   vga_burst_read_*           VGA request/address in, ready/data out
//   m_request/m_write/m_address/m_length/m_writedata
//                              general master transfer description
//   m_ready/m_readdata/m_done  master beat strobe, read data, end-of-transfer pulse
//   ssram_request/ssram_write/ssram_address/ssram_writedata
//                              burst command and write data to drv_ssram
//   ssram_ready/ssram_readdata per-beat strobe and read data from drv_ssram

module ssram_burst_arbiter #(
   parameter int VGA_BURST_WORDS = 213,
   parameter int M_CHUNK_WORDS   = 16
) (
   input  logic        clk_30,
   input  logic        reset_n,
   input  logic        vga_burst_read_request,
   input  logic [29:0] vga_burst_read_address,
   output logic        vga_burst_read_ready,
   output logic [35:0] vga_burst_read_data,
   input  logic        m_request,
   input  logic        m_write,
   input  logic [29:0] m_address,
   input  logic [7:0]  m_length,
   input  logic [35:0] m_writedata,
   output logic        m_ready,
   output logic [35:0] m_readdata,
   output logic        m_done,
   output logic        ssram_request,
   output logic        ssram_write,
   output logic [29:0] ssram_address,
   output logic [35:0] ssram_writedata,
   input  logic        ssram_ready,
   input  logic [35:0] ssram_readdata
);

   localparam int VGA_CW = $clog2(VGA_BURST_WORDS + 1);
   localparam int CW     = (VGA_CW > 8) ? VGA_CW : 8;

   localparam logic [CW-1:0] VGA_LAST  = CW'(VGA_BURST_WORDS);
   localparam logic [7:0]    CHUNK_MAX = 8'(M_CHUNK_WORDS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_VGA = 2'd1,
      GNT_M   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CW-1:0] beat_cnt;
   logic [7:0]    chunk;
   logic [7:0]    remaining;
   logic [29:0]   m_cur_addr;
   logic          m_latched;
   logic          m_wait_low;

   logic [CW-1:0] beat_inc;
   logic [7:0]    len_eff;
   logic          m_avail;
   logic [29:0]   m_addr_eff;
   logic [7:0]    rem_eff;
   logic [7:0]    chunk_eff;

   logic start_vga;
   logic start_m;
   logic vga_end;
   logic m_chunk_end;
   logic m_abort;

   // A master transfer that is not yet latched can still be granted in the
   // same IDLE cycle it is first seen: the effective address/length come
   // straight from the ports until the latch takes over.
   assign beat_inc   = beat_cnt + 1'b1;
   assign len_eff    = (m_length == 8'd0) ? 8'd1 : m_length;
   assign m_avail    = m_latched | (m_request & ~m_wait_low);
   assign m_addr_eff = m_latched ? m_cur_addr : m_address;
   assign rem_eff    = m_latched ? remaining : len_eff;
   assign chunk_eff  = (rem_eff < CHUNK_MAX) ? rem_eff : CHUNK_MAX;

   always_ff @(posedge clk_30 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      start_vga   = 1'b0;
      start_m     = 1'b0;
      vga_end     = 1'b0;
      m_chunk_end = 1'b0;
      m_abort     = 1'b0;
      case (state)
         IDLE: begin
            if (vga_burst_read_request) begin
               start_vga = 1'b1;
               state_nxt = GNT_VGA;
            end else if (m_request && m_avail) begin
               start_m   = 1'b1;
               state_nxt = GNT_M;
            end
         end
         GNT_VGA: begin
            if (!vga_burst_read_request || (ssram_ready && (beat_inc == VGA_LAST))) begin
               vga_end   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         GNT_M: begin
            if (!m_request) begin
               m_abort   = 1'b1;
               state_nxt = RELEASE;
            end else if (ssram_ready && (beat_inc == CW'(chunk))) begin
               m_chunk_end = 1'b1;
               state_nxt   = RELEASE;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_30 or negedge reset_n) begin
      if (!reset_n) begin
         ssram_request <= 1'b0;
         ssram_write   <= 1'b0;
         ssram_address <= '0;
         m_done        <= 1'b0;
         beat_cnt      <= '0;
         chunk         <= '0;
         remaining     <= '0;
         m_cur_addr    <= '0;
         m_latched     <= 1'b0;
         m_wait_low    <= 1'b0;
      end else begin
         m_done <= 1'b0;

         if (ssram_ready && ((state == GNT_VGA) || (state == GNT_M))) begin
            beat_cnt <= beat_inc;
         end

         if (start_vga) begin
            ssram_address <= vga_burst_read_address;
            ssram_write   <= 1'b0;
            ssram_request <= 1'b1;
            beat_cnt      <= '0;
         end

         if (start_m) begin
            ssram_address <= m_addr_eff;
            ssram_write   <= m_write;
            ssram_request <= 1'b1;
            beat_cnt      <= '0;
            chunk         <= chunk_eff;
         end

         if (vga_end || m_chunk_end || m_abort) begin
            ssram_request <= 1'b0;
         end

         // Latch a new master transfer; this can coincide with a VGA grant
         // so the master resumes from the latched state later.
         if ((state == IDLE) && !m_latched && m_request && !m_wait_low) begin
            m_latched  <= 1'b1;
            m_cur_addr <= m_address;
            remaining  <= len_eff;
         end

         if (m_chunk_end) begin
            m_cur_addr <= m_cur_addr + 30'(chunk);
            remaining  <= remaining - chunk;
            if (remaining == chunk) begin
               m_done     <= 1'b1;
               m_latched  <= 1'b0;
               m_wait_low <= 1'b1;
            end
         end

         // A master that lets go of its request outside a grant abandons the
         // transfer just like an in-grant abort.
         if (m_abort || (!m_request && (state != GNT_M))) begin
            m_latched <= 1'b0;
         end

         if (!m_request) begin
            m_wait_low <= 1'b0;
         end
      end
   end

   assign vga_burst_read_ready = ssram_ready & (state == GNT_VGA);
   assign vga_burst_read_data  = ssram_readdata;
   assign m_ready              = ssram_ready & (state == GNT_M);
   assign m_readdata           = ssram_readdata;
   assign ssram_writedata      = (state == GNT_M) ? m_writedata : '0;

endmodule

// File: tb/tb_ssram_burst_arbiter.sv
// tb/tb_ssram_burst_arbiter.sv - directed self-checking bench for ssram_burst_arbiter

module tb_ssram_burst_arbiter;

   localparam int VW = 213;

   logic        clk_30 = 1'b0;
   logic        reset_n;
   logic        vga_req;
   logic [29:0] vga_addr;
   logic        vga_ready;
   logic [35:0] vga_data;
   logic        m_request;
   logic        m_write;
   logic [29:0] m_address;
   logic [7:0]  m_length;
   logic [35:0] m_writedata;
   logic        m_ready;
   logic [35:0] m_readdata;
   logic        m_done;
   logic        ssram_request;
   logic        ssram_write;
   logic [29:0] ssram_address;
   logic [35:0] ssram_writedata;
   logic        ssram_ready;
   logic [35:0] ssram_readdata;
   logic        ready_en;

   int total = 0;
   int bad   = 0;

   always #5 clk_30 = ~clk_30;

   assign ssram_ready = ssram_request & ready_en;

   ssram_burst_arbiter dut (
      .clk_30                 (clk_30),
      .reset_n                (reset_n),
      .vga_burst_read_request (vga_req),
      .vga_burst_read_address (vga_addr),
      .vga_burst_read_ready   (vga_ready),
      .vga_burst_read_data    (vga_data),
      .m_request              (m_request),
      .m_write                (m_write),
      .m_address              (m_address),
      .m_length               (m_length),
      .m_writedata            (m_writedata),
      .m_ready                (m_ready),
      .m_readdata             (m_readdata),
      .m_done                 (m_done),
      .ssram_request          (ssram_request),
      .ssram_write            (ssram_write),
      .ssram_address          (ssram_address),
      .ssram_writedata        (ssram_writedata),
      .ssram_ready            (ssram_ready),
      .ssram_readdata         (ssram_readdata)
   );

   // Grant log: one entry per ssram_request high period.
   logic [29:0] g_addr[$];
   logic        g_wr[$];
   int          g_beats[$];
   int          g_gap[$];
   int          cur_beats = 0;
   int          low_run   = 0;
   logic        req_q     = 1'b0;
   int          vga_total = 0;
   int          m_total   = 0;
   int          done_total = 0;
   int          vga_base  = 0;
   int          m_base    = 0;

   always @(negedge clk_30) begin
      if (ssram_request && !req_q) begin
         g_addr.push_back(ssram_address);
         g_wr.push_back(ssram_write);
         g_gap.push_back(low_run);
         cur_beats = 0;
      end
      if (ssram_request && (vga_ready || m_ready)) cur_beats++;
      if (!ssram_request && req_q) g_beats.push_back(cur_beats);
      low_run = ssram_request ? 0 : low_run + 1;
      if (vga_ready) vga_total++;
      if (m_ready) m_total++;
      if (m_done) done_total++;
      req_q = ssram_request;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_30);
      #1;
   endtask

   // Plays the requesters: drops VGA after VW beats, drops the master on
   // m_done, optionally raises VGA after trig master beats, optionally
   // stalls ssram_ready.
   task automatic service(input bit stall, input int trig, input int bound);
      bit raised;
      bit to;
      raised = (trig < 0);
      to = 1'b1;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk_30);
         #1;
         ready_en = stall ? ((i % 4) != 1) : 1'b1;
         @(negedge clk_30);
         #1;
         if (!raised && (m_total - m_base >= trig)) begin
            vga_base = vga_total;
            vga_req  = 1'b1;
            raised   = 1'b1;
         end
         if (vga_req && (vga_total - vga_base >= VW)) vga_req = 1'b0;
         if (m_request && m_done) m_request = 1'b0;
         if (raised && !vga_req && !m_request && !ssram_request) begin
            to = 1'b0;
            break;
         end
      end
      ready_en = 1'b1;
      check("service_timeout", to, 0);
      tick();
      tick();
   endtask

   initial begin
      int n0;
      int d0;
      int v0;
      reset_n        = 1'b0;
      vga_req        = 1'b0;
      vga_addr       = '0;
      m_request      = 1'b0;
      m_write        = 1'b0;
      m_address      = '0;
      m_length       = '0;
      m_writedata    = 36'hA_BCDE_F012;
      ssram_readdata = 36'h5_1234_5678;
      ready_en       = 1'b1;

      // Reset state
      tick(); tick(); tick();
      check("rst_req", ssram_request, 0);
      check("rst_write", ssram_write, 0);
      check("rst_addr", ssram_address, 0);
      check("rst_done", m_done, 0);
      check("rst_mready", m_ready, 0);
      check("rst_vready", vga_ready, 0);
      reset_n = 1'b1;
      tick();

      // VGA only
      n0 = g_addr.size(); m_base = m_total;
      vga_addr = 30'h0406_0000;
      vga_base = vga_total;
      vga_req = 1'b1;
      @(negedge clk_30); #1;
      check("t1_latency0", ssram_request, 0);
      tick();
      check("t1_req", ssram_request, 1);
      check("t1_addr", ssram_address, 30'h0406_0000);
      check("t1_write", ssram_write, 0);
      check("t1_vdata", vga_data, 36'h5_1234_5678);
      service(1'b0, -1, 600);
      check("t1_grants", g_addr.size() - n0, 1);
      check("t1_beats", g_beats[n0], VW);
      check("t1_vga_total", vga_total - vga_base, VW);
      check("t1_no_mready", m_total - m_base, 0);
      check("t1_req_low", ssram_request, 0);

      // Master write of 40 words in chunks of 16
      n0 = g_addr.size(); m_base = m_total; d0 = done_total;
      m_address = 30'h0000_0100; m_length = 8'd40; m_write = 1'b1;
      m_request = 1'b1;
      tick();
      check("t2_req", ssram_request, 1);
      check("t2_write", ssram_write, 1);
      check("t2_wdata", ssram_writedata, 36'hA_BCDE_F012);
      service(1'b1, -1, 600);
      check("t2_grants", g_addr.size() - n0, 3);
      check("t2_addr0", g_addr[n0], 30'h0000_0100);
      check("t2_addr1", g_addr[n0+1], 30'h0000_0110);
      check("t2_addr2", g_addr[n0+2], 30'h0000_0120);
      check("t2_beats0", g_beats[n0], 16);
      check("t2_beats1", g_beats[n0+1], 16);
      check("t2_beats2", g_beats[n0+2], 8);
      check("t2_gap1", g_gap[n0+1], 2);
      check("t2_gap2", g_gap[n0+2], 2);
      check("t2_wr2", g_wr[n0+2], 1);
      check("t2_done", done_total - d0, 1);
      check("t2_mbeats", m_total - m_base, 40);

      // VGA arrives during first master chunk; address wraps at 2^30
      n0 = g_addr.size(); m_base = m_total; d0 = done_total; v0 = vga_total;
      vga_addr = 30'h0000_2000;
      m_address = 30'h3FFF_FFF8; m_length = 8'd32; m_write = 1'b0;
      m_request = 1'b1;
      service(1'b1, 3, 2000);
      check("t3_grants", g_addr.size() - n0, 3);
      check("t3_addr0", g_addr[n0], 30'h3FFF_FFF8);
      check("t3_addr1", g_addr[n0+1], 30'h0000_2000);
      check("t3_addr2", g_addr[n0+2], 30'h0000_0008);
      check("t3_beats0", g_beats[n0], 16);
      check("t3_beats1", g_beats[n0+1], VW);
      check("t3_beats2", g_beats[n0+2], 16);
      check("t3_wr0", g_wr[n0], 0);
      check("t3_done", done_total - d0, 1);
      check("t3_vbeats", vga_total - v0, VW);

      // Simultaneous VGA and master from IDLE
      n0 = g_addr.size(); m_base = m_total; d0 = done_total;
      vga_addr = 30'h0000_1234;
      m_address = 30'h0000_5000; m_length = 8'd4;
      vga_base = vga_total;
      vga_req = 1'b1;
      m_request = 1'b1;
      service(1'b0, -1, 600);
      check("t4_grants", g_addr.size() - n0, 2);
      check("t4_addr0", g_addr[n0], 30'h0000_1234);
      check("t4_addr1", g_addr[n0+1], 30'h0000_5000);
      check("t4_beats0", g_beats[n0], VW);
      check("t4_beats1", g_beats[n0+1], 4);
      check("t4_done", done_total - d0, 1);

      // m_length = 0 is one word
      n0 = g_addr.size(); m_base = m_total; d0 = done_total;
      m_address = 30'h0000_0777; m_length = 8'd0;
      m_request = 1'b1;
      service(1'b0, -1, 100);
      check("t5_grants", g_addr.size() - n0, 1);
      check("t5_beats", g_beats[n0], 1);
      check("t5_done", done_total - d0, 1);
      check("t5_mbeats", m_total - m_base, 1);

      // Abort after 5 beats
      n0 = g_addr.size(); m_base = m_total; d0 = done_total;
      m_address = 30'h0000_0900; m_length = 8'd16;
      m_request = 1'b1;
      begin
         bit to;
         to = 1'b1;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk_30); #1;
            if (m_total - m_base >= 5) begin
               m_request = 1'b0;
               to = 1'b0;
               break;
            end
         end
         check("t6_timeout", to, 0);
      end
      tick();
      check("t6_req_fell", ssram_request, 0);
      tick(); tick();
      check("t6_beats", g_beats[n0], 5);
      check("t6_no_done", done_total - d0, 0);

      // Fresh transfer after abort starts at its own address
      n0 = g_addr.size(); d0 = done_total;
      m_address = 30'h0000_0AAA; m_length = 8'd2;
      m_request = 1'b1;
      service(1'b0, -1, 100);
      check("t7_addr", g_addr[n0], 30'h0000_0AAA);
      check("t7_beats", g_beats[n0], 2);
      check("t7_done", done_total - d0, 1);

      // Request held high after m_done must not start another transfer
      n0 = g_addr.size(); d0 = done_total;
      m_address = 30'h0000_0C00; m_length = 8'd1;
      m_request = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t8_grants", g_addr.size() - n0, 1);
      check("t8_done", done_total - d0, 1);
      m_request = 1'b0;
      tick(); tick();

      // Reset in the middle of a VGA burst
      vga_addr = 30'h0000_0040;
      vga_base = vga_total;
      vga_req = 1'b1;
      begin
         bit to;
         to = 1'b1;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (vga_total - vga_base >= 50) begin
               to = 1'b0;
               break;
            end
         end
         check("t9_timeout", to, 0);
      end
      reset_n = 1'b0;
      #1;
      check("t9_req", ssram_request, 0);
      check("t9_addr", ssram_address, 0);
      check("t9_vready", vga_ready, 0);
      check("t9_mready", m_ready, 0);
      check("t9_done", m_done, 0);
      vga_req = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      n0 = g_addr.size();
      vga_addr = 30'h0100_0000;
      vga_base = vga_total;
      vga_req = 1'b1;
      tick();
      check("t9_new_req", ssram_request, 1);
      service(1'b0, -1, 600);
      check("t9_new_addr", g_addr[n0], 30'h0100_0000);
      check("t9_new_beats", g_beats[n0], VW);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
